// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage: upstream push side, downstream pop
// side, synchronous flush and the two performance counters.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    // A transfer happens on a rising edge where valid & ready are both high;
    // valid and data stay stable until that edge, and ready may not depend on valid.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, stall_cnt, flush_cnt
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional skid entry, synchronous flush and
// saturating stall/flush counters.
module pipe_stage_reg #(
    parameter int               WIDTH       = 64,
    parameter int               SKID        = 1,
    parameter logic [WIDTH-1:0] NOP_PAYLOAD = '0,
    parameter int               CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_stage_reg_if.slave       bus,
    output logic [1:0]            dbg_state_o
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic in_ready;
    logic out_valid;
    logic accept;
    logic consume;

    // Skid mode uses a registered ready; single-entry mode lets a pop make room in the same cycle.
    assign in_ready  = (SKID != 0) ? in_ready_q : ((state_q == ST_EMPTY) | bus.out_ready);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = bus.in_valid & in_ready;
    assign consume   = out_valid & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = bus.in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_d = bus.in_data;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end else if (accept && (SKID != 0)) begin
                        state_d = ST_TWO;
                        skid_d  = bus.in_data;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        if (out_valid && !bus.out_ready && !bus.flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        // Only flushes that actually killed something are worth counting.
        if (bus.flush && (out_valid || bus.in_valid) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end

        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? main_q : NOP_PAYLOAD;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg in skid and single-entry modes.
module tb_pipe_stage_reg;
    localparam logic [7:0] NOP = 8'hEE;

    logic clk;
    logic rst;
    logic [1:0] st1;
    logic [1:0] st0;
    int total;
    int bad;

    pipe_stage_reg_if #(.WIDTH(8), .CNT_W(4)) b1();
    pipe_stage_reg_if #(.WIDTH(8), .CNT_W(4)) b0();

    pipe_stage_reg #(.WIDTH(8), .SKID(1), .NOP_PAYLOAD(NOP), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .dbg_state_o(st1)
    );
    pipe_stage_reg #(.WIDTH(8), .SKID(0), .NOP_PAYLOAD(NOP), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .bus(b0), .dbg_state_o(st0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       fl;
        logic       ov;
        logic [7:0] od;
        logic       ir;
        logic [1:0] sta;
        logic [3:0] st;
        logic [3:0] fc;
    } vec_t;

    vec_t t1[21];
    vec_t t0[11];

    function automatic vec_t mk(logic iv, logic [7:0] id, logic ordy, logic fl, logic ov,
                                logic [7:0] od, logic ir, logic [1:0] sta, logic [3:0] st,
                                logic [3:0] fc);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl; v.ov = ov;
        v.od = od; v.ir = ir; v.sta = sta; v.st = st; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        b1.in_valid = iv; b1.in_data = id; b1.out_ready = ordy; b1.flush = fl;
    endtask

    task automatic drive0(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        b0.in_valid = iv; b0.in_data = id; b0.out_ready = ordy; b0.flush = fl;
    endtask

    task automatic run_row(input bit sel, input int idx, input vec_t v);
        string p;
        @(negedge clk);
        p = $sformatf("%s[%0d]", sel ? "skid" : "single", idx);
        if (sel) begin
            drive1(v.iv, v.id, v.ordy, v.fl);
            #1;
            chk({p, ".out_valid"}, 32'(b1.out_valid), 32'(v.ov));
            chk({p, ".out_data"},  32'(b1.out_data),  32'(v.od));
            chk({p, ".in_ready"},  32'(b1.in_ready),  32'(v.ir));
            chk({p, ".state"},     32'(st1),          32'(v.sta));
            chk({p, ".stall_cnt"}, 32'(b1.stall_cnt), 32'(v.st));
            chk({p, ".flush_cnt"}, 32'(b1.flush_cnt), 32'(v.fc));
        end else begin
            drive0(v.iv, v.id, v.ordy, v.fl);
            #1;
            chk({p, ".out_valid"}, 32'(b0.out_valid), 32'(v.ov));
            chk({p, ".out_data"},  32'(b0.out_data),  32'(v.od));
            chk({p, ".in_ready"},  32'(b0.in_ready),  32'(v.ir));
            chk({p, ".state"},     32'(st0),          32'(v.sta));
            chk({p, ".stall_cnt"}, 32'(b0.stall_cnt), 32'(v.st));
            chk({p, ".flush_cnt"}, 32'(b0.flush_cnt), 32'(v.fc));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Skid mode: rows are {iv, id, out_ready, flush | out_valid, out_data, in_ready, state, stall, flush_cnt}
        t1[0]  = mk(1, 8'h01, 1, 0, 0, NOP,   1, 0, 0, 0);
        t1[1]  = mk(1, 8'h02, 1, 0, 1, 8'h01, 1, 1, 0, 0);
        t1[2]  = mk(1, 8'h03, 1, 0, 1, 8'h02, 1, 1, 0, 0);
        t1[3]  = mk(0, 8'h00, 1, 0, 1, 8'h03, 1, 1, 0, 0);
        t1[4]  = mk(0, 8'h00, 0, 0, 0, NOP,   1, 0, 0, 0);
        t1[5]  = mk(1, 8'h0A, 0, 0, 0, NOP,   1, 0, 0, 0);
        t1[6]  = mk(1, 8'h0B, 0, 0, 1, 8'h0A, 1, 1, 0, 0);
        t1[7]  = mk(1, 8'h0C, 0, 0, 1, 8'h0A, 0, 2, 1, 0);
        t1[8]  = mk(1, 8'h0C, 0, 0, 1, 8'h0A, 0, 2, 2, 0);
        t1[9]  = mk(1, 8'h0C, 1, 0, 1, 8'h0A, 0, 2, 3, 0);
        t1[10] = mk(1, 8'h0C, 1, 0, 1, 8'h0B, 1, 1, 3, 0);
        t1[11] = mk(0, 8'h00, 1, 0, 1, 8'h0C, 1, 1, 3, 0);
        t1[12] = mk(0, 8'h00, 0, 0, 0, NOP,   1, 0, 3, 0);
        t1[13] = mk(1, 8'h11, 0, 0, 0, NOP,   1, 0, 3, 0);
        t1[14] = mk(1, 8'h22, 0, 0, 1, 8'h11, 1, 1, 3, 0);
        t1[15] = mk(1, 8'h33, 0, 1, 1, 8'h11, 0, 2, 4, 0);
        t1[16] = mk(0, 8'h00, 1, 0, 0, NOP,   1, 0, 4, 1);
        t1[17] = mk(0, 8'h00, 1, 0, 0, NOP,   1, 0, 4, 1);
        t1[18] = mk(0, 8'h00, 1, 1, 0, NOP,   1, 0, 4, 1);
        t1[19] = mk(1, 8'h44, 1, 1, 0, NOP,   1, 0, 4, 1);
        t1[20] = mk(0, 8'h00, 1, 0, 0, NOP,   1, 0, 4, 2);

        // Single-entry mode
        t0[0]  = mk(1, 8'h51, 0, 0, 0, NOP,   1, 0, 0, 0);
        t0[1]  = mk(1, 8'h52, 0, 0, 1, 8'h51, 0, 1, 0, 0);
        t0[2]  = mk(1, 8'h52, 0, 0, 1, 8'h51, 0, 1, 1, 0);
        t0[3]  = mk(1, 8'h52, 1, 0, 1, 8'h51, 1, 1, 2, 0);
        t0[4]  = mk(1, 8'h53, 1, 0, 1, 8'h52, 1, 1, 2, 0);
        t0[5]  = mk(1, 8'h54, 1, 0, 1, 8'h53, 1, 1, 2, 0);
        t0[6]  = mk(0, 8'h00, 1, 0, 1, 8'h54, 1, 1, 2, 0);
        t0[7]  = mk(0, 8'h00, 0, 0, 0, NOP,   1, 0, 2, 0);
        t0[8]  = mk(1, 8'hFF, 0, 0, 0, NOP,   1, 0, 2, 0);
        t0[9]  = mk(0, 8'h00, 0, 1, 1, 8'hFF, 0, 1, 2, 0);
        t0[10] = mk(0, 8'h00, 0, 0, 0, NOP,   1, 0, 2, 1);

        // Reset block
        rst = 1'b0;
        drive1(0, 8'h00, 0, 0);
        drive0(0, 8'h00, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.skid.out_valid", 32'(b1.out_valid), 32'd0);
        chk("rst.skid.out_data",  32'(b1.out_data),  32'(NOP));
        chk("rst.skid.in_ready",  32'(b1.in_ready),  32'd0);
        chk("rst.skid.stall_cnt", 32'(b1.stall_cnt), 32'd0);
        chk("rst.skid.flush_cnt", 32'(b1.flush_cnt), 32'd0);
        chk("rst.single.in_ready", 32'(b0.in_ready), 32'd1);
        rst = 1'b1;
        #1;
        chk("release.skid.in_ready", 32'(b1.in_ready), 32'd0);

        for (int i = 0; i < 21; i++) run_row(1'b1, i, t1[i]);

        // Stall counter saturation: hold one entry with out_ready low for 20 edges.
        @(negedge clk);
        drive1(1, 8'h5A, 0, 0);
        @(negedge clk);
        drive1(0, 8'h00, 0, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("sat.stall_cnt", 32'(b1.stall_cnt), 32'd15);
        chk("sat.state",     32'(st1),          32'd1);
        chk("sat.out_data",  32'(b1.out_data),  32'h5A);
        @(negedge clk);
        #1;
        chk("sat.stall_hold", 32'(b1.stall_cnt), 32'd15);

        // Asynchronous reset between edges while holding an entry.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.out_valid", 32'(b1.out_valid), 32'd0);
        chk("arst.out_data",  32'(b1.out_data),  32'(NOP));
        chk("arst.stall_cnt", 32'(b1.stall_cnt), 32'd0);
        chk("arst.flush_cnt", 32'(b1.flush_cnt), 32'd0);
        chk("arst.in_ready",  32'(b1.in_ready),  32'd0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        drive1(0, 8'h00, 1, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("arst.post.out_valid", 32'(b1.out_valid), 32'd0);
        chk("arst.post.out_data",  32'(b1.out_data),  32'(NOP));
        chk("arst.post.in_ready",  32'(b1.in_ready),  32'd1);

        for (int i = 0; i < 11; i++) run_row(1'b0, i, t0[i]);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 64, payload width in bits (for example PC + instruction word).
REQ-002 Parameter SKID, default 1, selects the mode: 1 = two-entry skid (full throughput, registered in_ready); 0 = single entry (combinational in_ready).
REQ-003 Parameter NOP_PAYLOAD, default '0, is the value driven on out_data whenever out_valid=0.
REQ-004 Parameter CNT_W, default 16, sets the width of the performance counters.
REQ-005 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  is the reset: asynchronous, active-low (asserted at 0).
REQ-007 in_valid  input  1  signals that the upstream stage presents a payload.
REQ-008 in_ready  output  1  signals that the stage accepts a payload this cycle.
REQ-009 in_data  input  WIDTH  carries the upstream payload.
REQ-010 flush  input  1  is a synchronous kill of all held and incoming payloads.
REQ-011 out_valid  output  1  signals that the stage presents a payload downstream.
REQ-012 out_ready  input  1  signals that the downstream stage consumes the payload.
REQ-013 out_data  output  WIDTH  carries the head payload, or NOP_PAYLOAD when out_valid=0.
REQ-014 stall_cnt  output  CNT_W  counts back-pressure cycles and saturates.
REQ-015 flush_cnt  output  CNT_W  counts flushes that killed at least one valid payload, and saturates.

Function
REQ-016 Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready; both are sampled at the rising edge.
REQ-017 The stage holds at most 1 entry (SKID=0) or 2 entries (SKID=1): a main entry driving the outputs, plus a skid entry.
REQ-018 The state machine has three states: EMPTY (0 entries), ONE (main valid), TWO (main+skid valid, reachable only when SKID=1).
REQ-019 EMPTY transitions: accept -> ONE, with main <= in_data; otherwise the stage stays EMPTY.
REQ-020 ONE transitions: accept & consume -> ONE with main <= in_data; consume only -> EMPTY; accept only -> TWO with skid <= in_data (SKID=1).
REQ-021 TWO transitions: consume -> ONE with main <= skid; no accept is possible while in TWO.
REQ-022 in_ready is (state != TWO) when SKID=1, and is a registered signal.
REQ-023 in_ready is (state == EMPTY) | out_ready when SKID=0.
REQ-024 Latency is exactly 1 cycle from accept to out_valid when the stage is EMPTY; payload order is strictly first-in first-out.
REQ-025 out_valid = (state != EMPTY); out_data = main when out_valid=1, else NOP_PAYLOAD.
REQ-026 Flush has top priority: on a flush edge the next state is EMPTY regardless of accept or consume.
REQ-027 During a flush cycle the incoming payload is dropped even if in_ready=1, and the handshake still completes upstream.
REQ-028 During a flush cycle a consume with out_ready=1 still counts as delivered downstream; flush only prevents future presentation.
REQ-029 stall_cnt increments on every edge where out_valid=1, out_ready=0 and flush=0.
REQ-030 flush_cnt increments on every flush edge where state != EMPTY or in_valid=1.
REQ-031 Both counters saturate at 2^CNT_W-1 and never wrap.
REQ-032 An all-ones payload and WIDTH=1 are legal; behaviour is identical for every WIDTH >= 1.

Reset
REQ-033 While rst=0: state = EMPTY, out_valid=0, out_data=NOP_PAYLOAD, both counters 0.
REQ-034 While rst=0: in_ready=0 for SKID=1; in_ready follows REQ-023 for SKID=0.
REQ-035 Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.
REQ-036 After rst rises, the first accept is allowed on the second rising edge, which gives one cycle of in_ready=1 settle for SKID=1.

Verification
REQ-037 SKID=1, out_ready=1, in_valid=1 every cycle with data 1,2,3,... -> out_data 1,2,3,... on consecutive cycles, in_ready always 1, stall_cnt=0.
REQ-038 SKID=1, push A, B with out_ready=0 -> state TWO, in_ready=0, out_data=A; raise out_ready -> A then B delivered, stall_cnt equals the number of held cycles.
REQ-039 SKID=0, out_ready=0 with one entry held -> in_ready=0; out_ready=1 with in_valid=1 -> replace-in-place, throughput 1 per cycle.
REQ-040 State TWO with flush=1 and in_valid=1 (data C) -> next cycle out_valid=0, out_data=NOP_PAYLOAD, C never appears, flush_cnt=1.
REQ-041 Force stall_cnt to 2^CNT_W-1 (CNT_W=4, 20 stall cycles) -> stall_cnt holds at 15.
REQ-042 Assert rst=0 asynchronously between edges while in state ONE -> out_valid falls to 0 immediately, counters read 0, and no stale payload appears after release.
